// File: rtl/rv32i_types.sv
// Shared RV32I type definitions: the basic word and write-mask types, plus the
// store-buffer entry record and its drain-FSM state encoding.
`timescale 1ns/1ps
package rv32i_types;

  // Architectural data word.
  typedef logic [31:0] rv32i_word;

  // Per-byte write enables, already shifted into lane position.
  typedef logic [3:0]  rv32i_mem_wmask;

  // One buffered store. Only the word address is kept, because the byte lanes
  // are already encoded in wmask.
  typedef struct packed {
    logic [29:0]    addr;
    rv32i_word      wdata;
    rv32i_mem_wmask wmask;
  } sb_entry_t;

  // Drain FSM. IDLE waits for a pending entry. ISSUE presents the head entry
  // to the dcache until the dcache acknowledges it.
  typedef enum logic {
    SB_IDLE  = 1'b0,
    SB_ISSUE = 1'b1
  } sb_state_t;

  // Word index of a byte address.
  function automatic logic [29:0] word_of(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/dcache_store_buffer.sv
// Data-cache store buffer.
//
// Stores from the pipeline are queued in a small circular FIFO. A two-state
// FSM drains the FIFO to the dcache one word at a time, in strict enqueue
// order. Stores are never coalesced and never forwarded to loads. Instead, a
// load whose word overlaps any pending store (including the one currently in
// flight) is flagged so the pipeline can stall it.
`timescale 1ns/1ps
module dcache_store_buffer
  import rv32i_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,

  // Store port from the pipeline
  input  logic           st_valid,
  input  logic [31:0]    st_addr,
  input  rv32i_word      st_wdata,
  input  rv32i_mem_wmask st_wmask,
  output logic           st_ready,

  // Load hazard check
  input  logic           ld_check,
  input  logic [31:0]    ld_addr,
  output logic           ld_conflict,

  // Write port to the dcache
  output logic           dmem_write,
  output logic [31:0]    dmem_address,
  output rv32i_word      dmem_wdata,
  output rv32i_mem_wmask dmem_byte_enable,
  input  logic           dmem_resp,

  // Status
  output logic           sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  // ---------------------------------------------------------------------------
  // Storage and bookkeeping
  // ---------------------------------------------------------------------------
  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  sb_state_t        state;

  // Registered copies of the head entry, presented to the dcache while in
  // ISSUE and held at zero while in IDLE.
  logic [31:0]      dmem_address_q;
  rv32i_word        dmem_wdata_q;
  rv32i_mem_wmask   dmem_byte_enable_q;

  // Slot occupancy, derived from the head pointer and the count.
  logic [PTR_W-1:0] slot_offset [DEPTH];
  logic [DEPTH-1:0] slot_valid;
  logic             ld_hit;

  logic             push;
  logic             pop;

  // Byte-offset bits of both addresses are intentionally ignored.
  logic             unused_low_bits;
  assign unused_low_bits = ^{st_addr[1:0], ld_addr[1:0]};

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // Acceptance looks only at the current count. A pop at the same edge does
  // not open a slot early, so a full buffer refuses stores for that cycle.
  assign st_ready = (count != FULL_COUNT);
  assign push     = st_valid && st_ready;

  // A completion is only meaningful while a write is outstanding. dmem_resp
  // seen in IDLE is ignored.
  assign pop      = (state == SB_ISSUE) && dmem_resp;

  // ---------------------------------------------------------------------------
  // Entry storage: written at the tail on every accepted store
  // ---------------------------------------------------------------------------
  // NOTE: the entry array has no reset. Occupancy is tracked entirely by
  // head/tail/count, so stale data in an unused slot is never observed, and
  // leaving the array unreset lets it map onto plain storage cells.
  always_ff @(posedge clk) begin
    if (push) begin
      entries[tail] <= '{addr:  word_of(st_addr),
                         wdata: st_wdata,
                         wmask: st_wmask};
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO pointers and occupancy count
  // ---------------------------------------------------------------------------
  // NOTE: every sequential block uses non-blocking assignments, so that all
  // registers sample their pre-edge values and the block order cannot change
  // behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + PTR_ONE;
      end
      if (pop) begin
        head <= head + PTR_ONE;
      end
      // A simultaneous enqueue and pop moves both pointers and leaves the
      // count unchanged.
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Drain FSM with registered dcache outputs
  // ---------------------------------------------------------------------------
  // The head entry is captured when the FSM enters ISSUE. The head pointer
  // cannot move until the pop that leaves ISSUE, so the captured value equals
  // the live head entry for the whole write. Leaving ISSUE always passes back
  // through IDLE, which inserts the required idle cycle between writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= SB_IDLE;
      dmem_address_q     <= '0;
      dmem_wdata_q       <= '0;
      dmem_byte_enable_q <= '0;
    end else begin
      unique case (state)
        SB_IDLE: begin
          if (count != '0) begin
            state              <= SB_ISSUE;
            dmem_address_q     <= {entries[head].addr, 2'b00};
            dmem_wdata_q       <= entries[head].wdata;
            dmem_byte_enable_q <= entries[head].wmask;
          end
        end
        SB_ISSUE: begin
          if (dmem_resp) begin
            state              <= SB_IDLE;
            dmem_address_q     <= '0;
            dmem_wdata_q       <= '0;
            dmem_byte_enable_q <= '0;
          end
        end
        default: begin
          state              <= SB_IDLE;
          dmem_address_q     <= '0;
          dmem_wdata_q       <= '0;
          dmem_byte_enable_q <= '0;
        end
      endcase
    end
  end

  assign dmem_write       = (state == SB_ISSUE);
  assign dmem_address     = dmem_address_q;
  assign dmem_wdata       = dmem_wdata_q;
  assign dmem_byte_enable = dmem_byte_enable_q;

  // ---------------------------------------------------------------------------
  // Slot occupancy: slot i is live when its distance from head is below count
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a value on every pass through the
  // block, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_offset[i] = PTR_W'(i) - head;
      slot_valid[i]  = ({1'b0, slot_offset[i]} < count);
    end
  end

  // ---------------------------------------------------------------------------
  // Load hazard: word-address match against every live slot
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slot_valid[i] && (entries[i].addr == word_of(ld_addr))) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign ld_conflict = ld_check && ld_hit;

  assign sb_empty = (count == '0) && (state == SB_IDLE);

  // ---------------------------------------------------------------------------
  // Structural sanity checks
  // ---------------------------------------------------------------------------
  // Occupancy can never exceed the number of slots.
  assert property (@(posedge clk) disable iff (!rst_n) count <= FULL_COUNT);

  // The write data path is quiet whenever no write is outstanding.
  assert property (@(posedge clk) disable iff (!rst_n)
                   (state == SB_IDLE) |-> (dmem_address_q == '0 &&
                                           dmem_wdata_q == '0 &&
                                           dmem_byte_enable_q == '0));

endmodule

// File: tb/tb_dcache_store_buffer.sv
// Self-checking bench for dcache_store_buffer: a directed vector table, a few
// hand-written multi-cycle sequences, and a randomized run compared against a
// queue-based reference model.
`timescale 1ns/1ps
module tb_dcache_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        st_ready;
  logic        ld_check;
  logic [31:0] ld_addr;
  logic        ld_conflict;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_byte_enable;
  logic        dmem_resp;
  logic        sb_empty;

  int n_vec  = 0;
  int n_miss = 0;

  dcache_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .st_valid         (st_valid),
    .st_addr          (st_addr),
    .st_wdata         (st_wdata),
    .st_wmask         (st_wmask),
    .st_ready         (st_ready),
    .ld_check         (ld_check),
    .ld_addr          (ld_addr),
    .ld_conflict      (ld_conflict),
    .dmem_write       (dmem_write),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_resp        (dmem_resp),
    .sb_empty         (sb_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d vectors, required completion", n_vec);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag,
                               input logic e_ready, input logic e_write,
                               input logic [31:0] e_addr, input logic [31:0] e_data,
                               input logic [3:0] e_be, input logic e_conf,
                               input logic e_empty);
    check({tag, ".st_ready"},         32'(st_ready),         32'(e_ready));
    check({tag, ".dmem_write"},       32'(dmem_write),       32'(e_write));
    check({tag, ".dmem_address"},     dmem_address,          e_addr);
    check({tag, ".dmem_wdata"},       dmem_wdata,            e_data);
    check({tag, ".dmem_byte_enable"}, 32'(dmem_byte_enable), 32'(e_be));
    check({tag, ".ld_conflict"},      32'(ld_conflict),      32'(e_conf));
    check({tag, ".sb_empty"},         32'(sb_empty),         32'(e_empty));
  endtask

  task automatic idle_inputs();
    st_valid  = 1'b0;
    st_addr   = '0;
    st_wdata  = '0;
    st_wmask  = '0;
    ld_check  = 1'b0;
    ld_addr   = '0;
    dmem_resp = 1'b0;
  endtask

  // Leaves the bench one time unit after a rising edge, buffer empty.
  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b1);
    rst_n = 1'b1;
  endtask

  // Wait (bounded) for a write, check it, then acknowledge it for one edge.
  task automatic expect_write(input string tag, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m);
    int waited = 0;
    while (dmem_write !== 1'b1 && waited < 20) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check({tag, ".write_seen"}, 32'(dmem_write), 32'd1);
    if (dmem_write === 1'b1) begin
      check({tag, ".addr"}, dmem_address, a);
      check({tag, ".data"}, dmem_wdata, d);
      check({tag, ".be"},   32'(dmem_byte_enable), 32'(m));
      dmem_resp = 1'b1;
      @(posedge clk);
      #1;
      dmem_resp = 1'b0;
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    st_valid = 1'b1;
    st_addr  = a;
    st_wdata = d;
    st_wmask = m;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_wmask;
    logic        ld_check;
    logic [31:0] ld_addr;
    logic        resp;
    logic        e_ready;
    logic        e_write;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic        e_conf;
    logic        e_empty;
  } vec_t;

  function automatic vec_t mk(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                              input logic [3:0] sm, input logic lc, input logic [31:0] la,
                              input logic rsp, input logic er, input logic ew,
                              input logic [31:0] ea, input logic [31:0] ed,
                              input logic [3:0] eb, input logic ec, input logic ee);
    vec_t v;
    v.st_valid = sv; v.st_addr = sa; v.st_wdata = sd; v.st_wmask = sm;
    v.ld_check = lc; v.ld_addr = la; v.resp = rsp;
    v.e_ready = er; v.e_write = ew; v.e_addr = ea; v.e_data = ed;
    v.e_be = eb; v.e_conf = ec; v.e_empty = ee;
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model for the randomized run: an ordered list of pending stores
  // plus a flag telling whether the oldest one is currently being written.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [29:0] word;
    logic [31:0] data;
    logic [3:0]  mask;
  } model_entry_t;

  model_entry_t model_q[$];
  bit           model_writing;

  initial begin
    vec_t tbl [16];

    // Rows: store inputs | load inputs | resp || expected outputs
    tbl[0]  = mk(0, 0, 0, 0,                           0, 0, 0,        1, 0, 0, 0, 0, 0, 1);
    tbl[1]  = mk(1, 32'h1006, 32'hABABABAB, 4'b0100,   0, 0, 0,        1, 0, 0, 0, 0, 0, 1);
    tbl[2]  = mk(0, 0, 0, 0,                           1, 32'h1007, 0, 1, 0, 0, 0, 0, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0,                           1, 32'h1004, 0, 1, 1, 32'h1004, 32'hABABABAB, 4'b0100, 1, 0);
    tbl[4]  = mk(0, 0, 0, 0,                           1, 32'h1008, 1, 1, 1, 32'h1004, 32'hABABABAB, 4'b0100, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0,                           1, 32'h1004, 1, 1, 0, 0, 0, 0, 0, 1);
    tbl[6]  = mk(0, 0, 0, 0,                           0, 0, 0,        1, 0, 0, 0, 0, 0, 1);
    tbl[7]  = mk(1, 32'h200, 32'h11223344, 4'hF,       0, 0, 0,        1, 0, 0, 0, 0, 0, 1);
    tbl[8]  = mk(0, 0, 0, 0,                           1, 32'h203, 0,  1, 0, 0, 0, 0, 1, 0);
    tbl[9]  = mk(0, 0, 0, 0,                           1, 32'h204, 0,  1, 1, 32'h200, 32'h11223344, 4'hF, 0, 0);
    tbl[10] = mk(0, 0, 0, 0,                           1, 32'h200, 1,  1, 1, 32'h200, 32'h11223344, 4'hF, 1, 0);
    tbl[11] = mk(0, 0, 0, 0,                           1, 32'h203, 0,  1, 0, 0, 0, 0, 0, 1);
    tbl[12] = mk(1, 32'h302, 32'hDEAD0000, 4'h0,       0, 0, 0,        1, 0, 0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 0, 0,                           0, 0, 0,        1, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(0, 0, 0, 0,                           0, 0, 1,        1, 1, 32'h300, 32'hDEAD0000, 4'h0, 0, 0);
    tbl[15] = mk(0, 0, 0, 0,                           0, 0, 0,        1, 0, 0, 0, 0, 0, 1);

    idle_inputs();
    rst_n = 1'b1;
    #2;
    do_reset();

    // Each row: drive, let combinational outputs settle, compare, clock.
    for (int r = 0; r < 16; r++) begin
      st_valid  = tbl[r].st_valid;
      st_addr   = tbl[r].st_addr;
      st_wdata  = tbl[r].st_wdata;
      st_wmask  = tbl[r].st_wmask;
      ld_check  = tbl[r].ld_check;
      ld_addr   = tbl[r].ld_addr;
      dmem_resp = tbl[r].resp;
      #1;
      check_outputs($sformatf("row%0d", r), tbl[r].e_ready, tbl[r].e_write, tbl[r].e_addr,
                    tbl[r].e_data, tbl[r].e_be, tbl[r].e_conf, tbl[r].e_empty);
      @(posedge clk);
      #1;
    end
    idle_inputs();

    // --- Fill to capacity with the dcache stalled, then drain in order -------
    for (int i = 0; i < DEPTH; i++) begin
      push_store(32'h4000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(1 << i));
    end
    check("fill.ready_after_4", 32'(st_ready), 32'd0);
    st_valid = 1'b1;
    st_addr  = 32'h5000;
    st_wdata = 32'hBAD0BAD0;
    st_wmask = 4'hF;
    #1;
    check("fill.ready_5th", 32'(st_ready), 32'd0);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("fill.ready_hold", 32'(st_ready), 32'd0);
    expect_write("fill0", 32'h4000, 32'hA000_0000, 4'b0001);
    check("fill.ready_after_pop", 32'(st_ready), 32'd1);
    for (int i = 1; i < DEPTH; i++) begin
      expect_write($sformatf("fill%0d", i), 32'h4000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'(1 << i));
    end
    repeat (3) begin
      @(posedge clk);
      #1;
      check("fill.no_5th_write", 32'(dmem_write), 32'd0);
    end
    check("fill.empty", 32'(sb_empty), 32'd1);

    // --- Simultaneous enqueue and pop at count=2, with tail wrap ------------
    push_store(32'h6000, 32'h0000_00A0, 4'hF);
    push_store(32'h6004, 32'h0000_00B0, 4'hF);
    check("wrap.write_A", 32'(dmem_write), 32'd1);
    check("wrap.addr_A", dmem_address, 32'h6000);
    st_valid  = 1'b1;
    st_addr   = 32'h6008;
    st_wdata  = 32'h0000_00C0;
    st_wmask  = 4'hF;
    dmem_resp = 1'b1;
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    st_addr   = 32'h600C;
    st_wdata  = 32'h0000_00D0;
    #1;
    check("wrap.ready_cnt2", 32'(st_ready), 32'd1);
    @(posedge clk);
    #1;
    check("wrap.ready_cnt3", 32'(st_ready), 32'd1);
    st_addr  = 32'h6010;
    st_wdata = 32'h0000_00E0;
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    check("wrap.ready_cnt4", 32'(st_ready), 32'd0);
    expect_write("wrapB", 32'h6004, 32'h0000_00B0, 4'hF);
    expect_write("wrapC", 32'h6008, 32'h0000_00C0, 4'hF);
    expect_write("wrapD", 32'h600C, 32'h0000_00D0, 4'hF);
    expect_write("wrapE", 32'h6010, 32'h0000_00E0, 4'hF);
    check("wrap.empty", 32'(sb_empty), 32'd1);

    // --- dmem_resp while IDLE must not pop ----------------------------------
    dmem_resp = 1'b1;
    push_store(32'h7000, 32'h7777_7777, 4'h3);
    #1;
    check("idle_resp.write0", 32'(dmem_write), 32'd0);
    check("idle_resp.not_empty", 32'(sb_empty), 32'd0);
    @(posedge clk);
    #1;
    dmem_resp = 1'b0;
    check("idle_resp.write1", 32'(dmem_write), 32'd1);
    check("idle_resp.addr", dmem_address, 32'h7000);
    @(posedge clk);
    #1;
    check("idle_resp.held", 32'(dmem_write), 32'd1);
    expect_write("idle_resp", 32'h7000, 32'h7777_7777, 4'h3);
    check("idle_resp.empty", 32'(sb_empty), 32'd1);

    // --- Reset in the middle of a write with 3 entries ----------------------
    push_store(32'h8000, 32'h1, 4'hF);
    push_store(32'h8004, 32'h2, 4'hF);
    push_store(32'h8008, 32'h3, 4'hF);
    check("rst_mid.writing", 32'(dmem_write), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.write", 32'(dmem_write), 32'd0);
    check("rst_mid.addr", dmem_address, 32'h0);
    check("rst_mid.empty", 32'(sb_empty), 32'd1);
    check("rst_mid.ready", 32'(st_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      dmem_resp = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("rst_mid.quiet%0d", i), 32'(dmem_write), 32'd0);
    end
    dmem_resp = 1'b0;
    check("rst_mid.still_empty", 32'(sb_empty), 32'd1);

    // --- Randomized run against the reference model -------------------------
    do_reset();
    model_q.delete();
    model_writing = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic        e_ready;
      logic        e_conf;
      logic        do_push;
      logic [31:0] e_addr;
      logic [31:0] e_data;
      logic [3:0]  e_be;

      st_valid  = ($urandom_range(0, 99) < 55);
      st_addr   = 32'h9000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      st_wdata  = $urandom;
      st_wmask  = 4'($urandom_range(0, 15));
      ld_check  = ($urandom_range(0, 99) < 60);
      ld_addr   = 32'h9000 | (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
      dmem_resp = ($urandom_range(0, 99) < 40);
      #1;

      e_ready = (model_q.size() < DEPTH);
      e_conf  = 1'b0;
      if (ld_check) begin
        foreach (model_q[k]) begin
          if (model_q[k].word == ld_addr[31:2]) e_conf = 1'b1;
        end
      end
      e_addr = '0;
      e_data = '0;
      e_be   = '0;
      if (model_writing) begin
        e_addr = {model_q[0].word, 2'b00};
        e_data = model_q[0].data;
        e_be   = model_q[0].mask;
      end
      check_outputs($sformatf("rand%0d", c), e_ready, model_writing, e_addr, e_data, e_be,
                    e_conf, (model_q.size() == 0) && !model_writing);

      // Advance the model by one edge.
      do_push = st_valid && e_ready;
      if (model_writing && dmem_resp) begin
        void'(model_q.pop_front());
        model_writing = 1'b0;
      end else if (!model_writing && model_q.size() != 0) begin
        model_writing = 1'b1;
      end
      if (do_push) begin
        model_q.push_back('{word: st_addr[31:2], data: st_wdata, mask: st_wmask});
      end

      @(posedge clk);
      #1;
    end
    idle_inputs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
